// File: rtl/ex_mdu_pkg.sv
// rtl/ex_mdu_pkg.sv - shared encodings and defaults for the EX-stage multiply/divide unit
package ex_mdu_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int MUL_LAT_DEF = 2;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic b_zero;
    logic q_neg;
    logic r_neg;
  } div_flags_t;

  // MULT/MULTU/DIV/DIVU are exactly the encodings with bit 2 clear.
  function automatic logic is_arith(input logic [2:0] op);
    return ~op[2];
  endfunction

endpackage

// File: rtl/ex_mdu_if.sv
// rtl/ex_mdu_if.sv - EX-stage pipeline <-> MDU signal bundle
interface ex_mdu_if
  import ex_mdu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);
  logic              flush;
  logic              ex_advance;
  logic              op_valid;
  logic [2:0]        op;
  logic [DATA_W-1:0] src_a;
  logic [DATA_W-1:0] src_b;
  logic              stallreq;
  logic              done;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  modport master (
    output flush, ex_advance, op_valid, op, src_a, src_b,
    input  stallreq, done, hi, lo
  );

  modport slave (
    input  flush, ex_advance, op_valid, op, src_a, src_b,
    output stallreq, done, hi, lo
  );
endinterface

// File: rtl/ex_mdu_div_iter.sv
// rtl/ex_mdu_div_iter.sv - restoring divider on unsigned magnitudes, one quotient bit per cycle
module ex_mdu_div_iter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic         kill_i,
  input  logic [W-1:0] dividend_i,
  input  logic [W-1:0] divisor_i,
  output logic         busy_o,
  output logic         last_o,
  output logic [W-1:0] quo_o,
  output logic [W-1:0] rem_o
);
  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic [W:0]    trial;
  logic          fits;
  logic [W-1:0]  rem_step, quo_step;

  always_comb begin
    trial    = {rem_q, quo_q[W-1]};
    fits     = trial >= {1'b0, dvs_q};
    rem_step = fits ? (trial[W-1:0] - dvs_q) : trial[W-1:0];
    quo_step = {quo_q[W-2:0], fits};

    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (kill_i) begin
      busy_d = 1'b0;
      cnt_d  = '0;
    end else if (start_i) begin
      rem_d  = '0;
      quo_d  = dividend_i;
      dvs_d  = divisor_i;
      cnt_d  = CW'(W);
      busy_d = 1'b1;
    end else if (busy_q) begin
      rem_d = rem_step;
      quo_d = quo_step;
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  // Final-iteration results are presented combinationally so the owner commits on the last edge.
  assign busy_o = busy_q;
  assign last_o = busy_q & (cnt_q == CW'(1));
  assign quo_o  = quo_step;
  assign rem_o  = rem_step;

endmodule

// File: rtl/ex_mdu.sv
// rtl/ex_mdu.sv - EX-stage multiply/divide unit owning HI/LO, with pipelined multiplier and iterative divider
module ex_mdu
  import ex_mdu_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int MUL_LAT = MUL_LAT_DEF
) (
  input logic     clk,
  input logic     rst,
  ex_mdu_if.slave mdu
);
  localparam int P_W    = 2 * DATA_W;
  localparam int CNT_MX = (MUL_LAT > DATA_W) ? MUL_LAT : DATA_W;
  localparam int CNT_W  = $clog2(CNT_MX + 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d, a_q, a_d;
  div_flags_t        flg_q, flg_d;
  logic              done_q, done_d;
  logic [P_W-1:0]    pipe_q [MUL_LAT];

  logic              op_arith, op_signed, issue, mt_we, mul_fin, div_fin;
  logic [P_W-1:0]    ext_a, ext_b, product;
  logic [DATA_W-1:0] mag_a, mag_b, quo_fix, rem_fix, div_quo, div_rem;
  logic              div_busy, div_last;

  assign op_arith  = is_arith(mdu.op);
  assign op_signed = ~mdu.op[0];
  assign issue     = (state_q == S_IDLE) & mdu.op_valid & op_arith & ~mdu.flush;
  assign mt_we     = mdu.op_valid & mdu.ex_advance & ~mdu.flush;

  // Low 2W bits of the sign-extended product equal the signed product.
  assign ext_a   = {{DATA_W{op_signed & mdu.src_a[DATA_W-1]}}, mdu.src_a};
  assign ext_b   = {{DATA_W{op_signed & mdu.src_b[DATA_W-1]}}, mdu.src_b};
  assign product = ext_a * ext_b;

  assign mag_a = (op_signed & mdu.src_a[DATA_W-1]) ? -mdu.src_a : mdu.src_a;
  assign mag_b = (op_signed & mdu.src_b[DATA_W-1]) ? -mdu.src_b : mdu.src_b;

  ex_mdu_div_iter #(.W(DATA_W)) u_div_iter (
    .clk        (clk),
    .rst        (rst),
    .start_i    (issue & mdu.op[1]),
    .kill_i     (mdu.flush),
    .dividend_i (mag_a),
    .divisor_i  (mag_b),
    .busy_o     (div_busy),
    .last_o     (div_last),
    .quo_o      (div_quo),
    .rem_o      (div_rem)
  );

  assign quo_fix = flg_q.q_neg ? -div_quo : div_quo;
  assign rem_fix = flg_q.r_neg ? -div_rem : div_rem;
  assign mul_fin = (state_q == S_MUL) & (cnt_q == CNT_W'(1)) & ~mdu.flush;
  assign div_fin = (state_q == S_DIV) & div_busy & div_last & ~mdu.flush;

  always_comb begin
    a_d   = a_q;
    flg_d = flg_q;
    if (issue) begin
      a_d          = mdu.src_a;
      flg_d.b_zero = (mdu.src_b == '0);
      flg_d.q_neg  = op_signed & (mdu.src_a[DATA_W-1] ^ mdu.src_b[DATA_W-1]);
      flg_d.r_neg  = op_signed & mdu.src_a[DATA_W-1];
    end

    hi_d   = hi_q;
    lo_d   = lo_q;
    done_d = mul_fin | div_fin;
    if (mul_fin) begin
      {hi_d, lo_d} = pipe_q[MUL_LAT-1];
    end else if (div_fin) begin
      hi_d = flg_q.b_zero ? a_q : rem_fix;
      lo_d = flg_q.b_zero ? '1  : quo_fix;
    end else if (mt_we && mdu.op == OP_MTHI) begin
      hi_d = mdu.src_a;
    end else if (mt_we && mdu.op == OP_MTLO) begin
      lo_d = mdu.src_a;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (issue) begin
        state_d = mdu.op[1] ? S_DIV : S_MUL;
        cnt_d   = mdu.op[1] ? CNT_W'(DATA_W) : CNT_W'(MUL_LAT);
      end
      S_MUL, S_DIV: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (mdu.flush) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (mul_fin || div_fin) begin
          state_d = S_DONE;
        end
      end
      // Held until EX drains so a later-stage stall cannot re-issue the same op.
      S_DONE: if (mdu.ex_advance || mdu.flush) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      flg_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      a_q     <= a_d;
      flg_q   <= flg_d;
      done_q  <= done_d;
    end
  end

  // Operands are held while stalled, so the stage-0 capture at the issue edge propagates intact.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MUL_LAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= product;
      for (int i = 1; i < MUL_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign mdu.stallreq = ~rst & mdu.op_valid & op_arith & (state_q != S_DONE);
  assign mdu.done     = done_q;
  assign mdu.hi       = hi_q;
  assign mdu.lo       = lo_q;

endmodule

// File: tb/tb_ex_mdu.sv
// tb/tb_ex_mdu.sv - directed vector bench for ex_mdu (32/2 instance plus 16/1 instance)
module tb_ex_mdu;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ex_mdu_if #(.DATA_W(32)) bus32 ();
  ex_mdu_if #(.DATA_W(16)) bus16 ();

  ex_mdu #(.DATA_W(32), .MUL_LAT(2)) dut32 (.clk(clk), .rst(rst), .mdu(bus32));
  ex_mdu #(.DATA_W(16), .MUL_LAT(1)) dut16 (.clk(clk), .rst(rst), .mdu(bus16));

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          stalls;
    logic        dn;
  } vec_t;

  vec_t tv [13];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Starts and ends at posedge+1; ex_advance follows stallreq like a real stall controller.
  task automatic run32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int stalls, output logic dn, output logic dn_after,
                       output logic [31:0] hi, output logic [31:0] lo);
    bus32.op_valid = 1'b1; bus32.op = op; bus32.src_a = a; bus32.src_b = b;
    bus32.ex_advance = 1'b0;
    stalls = 0; dn = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!bus32.stallreq) begin
        dn = bus32.done;
        bus32.ex_advance = 1'b1;
        break;
      end
      stalls++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    bus32.op_valid = 1'b0; bus32.op = 3'd0;
    @(negedge clk);
    dn_after = bus32.done; hi = bus32.hi; lo = bus32.lo;
    @(posedge clk); #1;
  endtask

  task automatic run16(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       output int stalls, output logic dn, output logic [31:0] hilo);
    bus16.op_valid = 1'b1; bus16.op = op; bus16.src_a = a; bus16.src_b = b;
    bus16.ex_advance = 1'b0;
    stalls = 0; dn = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!bus16.stallreq) begin
        dn = bus16.done;
        bus16.ex_advance = 1'b1;
        break;
      end
      stalls++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    bus16.op_valid = 1'b0;
    @(negedge clk);
    hilo = {bus16.hi, bus16.lo};
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] ref16(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    int sa, sb, q, r;
    logic [31:0] res;
    sa = int'($signed(a));
    sb = int'($signed(b));
    res = '0;
    case (op)
      3'd0: res = sa * sb;
      3'd1: res = {16'h0, a} * {16'h0, b};
      3'd2: if (b == 16'h0) res = {a, 16'hFFFF};
            else begin q = sa / sb; r = sa % sb; res = {r[15:0], q[15:0]}; end
      default: if (b == 16'h0) res = {a, 16'hFFFF};
               else res = {a % b, a / b};
    endcase
    return res;
  endfunction

  int          st, dc;
  logic        dn, dna, sh;
  logic [31:0] hi, lo, hilo, exp16;
  logic [15:0] ra, rb;
  logic [2:0]  rop;

  initial begin
    tv[0]  = '{3'd0, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 3,  1'b1};
    tv[1]  = '{3'd1, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 3,  1'b1};
    tv[2]  = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 3,  1'b1};
    tv[3]  = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33, 1'b1};
    tv[4]  = '{3'd2, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33, 1'b1};
    tv[5]  = '{3'd3, 32'hFFFFFFFF, 32'h10,       32'h0000000F, 32'h0FFFFFFF, 33, 1'b1};
    tv[6]  = '{3'd2, 32'd5,        32'd0,        32'h00000005, 32'hFFFFFFFF, 33, 1'b1};
    tv[7]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33, 1'b1};
    tv[8]  = '{3'd3, 32'd9,        32'd0,        32'h00000009, 32'hFFFFFFFF, 33, 1'b1};
    tv[9]  = '{3'd3, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 33, 1'b1};
    tv[10] = '{3'd4, 32'hCAFEF00D, 32'd0,        32'hCAFEF00D, 32'h0000000E, 0,  1'b0};
    tv[11] = '{3'd5, 32'h00001234, 32'd0,        32'hCAFEF00D, 32'h00001234, 0,  1'b0};
    tv[12] = '{3'd6, 32'h0000DEAD, 32'd1,        32'hCAFEF00D, 32'h00001234, 0,  1'b0};

    bus32.flush = 0; bus32.ex_advance = 0; bus32.op_valid = 1; bus32.op = 3'd0;
    bus32.src_a = 32'd3; bus32.src_b = 32'd4;
    bus16.flush = 0; bus16.ex_advance = 0; bus16.op_valid = 0; bus16.op = 3'd0;
    bus16.src_a = '0; bus16.src_b = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset.stallreq", 64'(bus32.stallreq), 64'd0);
    chk("reset.done",     64'(bus32.done),     64'd0);
    chk("reset.hi",       64'(bus32.hi),       64'd0);
    chk("reset.lo",       64'(bus32.lo),       64'd0);
    rst = 1'b0; bus32.op_valid = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) begin
      run32(tv[i].op, tv[i].a, tv[i].b, st, dn, dna, hi, lo);
      chk($sformatf("v%0d.stalls", i), 64'(st),  64'(tv[i].stalls));
      chk($sformatf("v%0d.done", i),   64'(dn),  64'(tv[i].dn));
      chk($sformatf("v%0d.done_after", i), 64'(dna), 64'd0);
      chk($sformatf("v%0d.hi", i),     64'(hi),  64'(tv[i].hi));
      chk($sformatf("v%0d.lo", i),     64'(lo),  64'(tv[i].lo));
    end

    // Flush a DIV on its 10th iteration cycle, then issue MULTU straight away.
    bus32.op_valid = 1; bus32.op = 3'd2; bus32.src_a = 32'd100; bus32.src_b = 32'd3;
    bus32.ex_advance = 0;
    repeat (10) begin @(posedge clk); #1; end
    bus32.flush = 1'b1;
    @(negedge clk);
    chk("flush.done_in", 64'(bus32.done), 64'd0);
    @(posedge clk); #1;
    bus32.flush = 1'b0;
    chk("flush.done_next", 64'(bus32.done), 64'd0);
    chk("flush.hi", 64'(bus32.hi), 64'hCAFEF00D);
    chk("flush.lo", 64'(bus32.lo), 64'h1234);
    run32(3'd1, 32'hFFFFFFFF, 32'd2, st, dn, dna, hi, lo);
    chk("flush.multu_stalls", 64'(st), 64'd3);
    chk("flush.multu_done",   64'(dn), 64'd1);
    chk("flush.multu_hi",     64'(hi), 64'd1);
    chk("flush.multu_lo",     64'(lo), 64'hFFFFFFFE);

    // MULT completes while EX is held by a later stall for four cycles.
    bus32.op_valid = 1; bus32.op = 3'd0; bus32.src_a = 32'd6; bus32.src_b = 32'd7;
    bus32.ex_advance = 0;
    st = 0; dc = 0; sh = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!bus32.stallreq) break;
      st++;
      @(posedge clk); #1;
    end
    for (int k = 0; k < 4; k++) begin
      dc += int'(bus32.done);
      sh |= bus32.stallreq;
      @(posedge clk); #1;
      @(negedge clk);
    end
    dc += int'(bus32.done);
    sh |= bus32.stallreq;
    chk("hold.stalls",    64'(st), 64'd3);
    chk("hold.stallreq",  64'(sh), 64'd0);
    chk("hold.done_cnt",  64'(dc), 64'd1);
    chk("hold.hi",        64'(bus32.hi), 64'd0);
    chk("hold.lo",        64'(bus32.lo), 64'd42);
    bus32.ex_advance = 1'b1;
    @(posedge clk); #1;
    run32(3'd5, 32'h1234, 32'd0, st, dn, dna, hi, lo);
    chk("mtlo.stalls", 64'(st), 64'd0);
    chk("mtlo.done",   64'(dn), 64'd0);
    chk("mtlo.hi",     64'(hi), 64'd0);
    chk("mtlo.lo",     64'(lo), 64'h1234);

    // Reset in the middle of a DIV.
    bus32.op_valid = 1; bus32.op = 3'd2; bus32.src_a = 32'd1000; bus32.src_b = 32'd3;
    bus32.ex_advance = 0;
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    chk("rst.stallreq", 64'(bus32.stallreq), 64'd0);
    chk("rst.hi",       64'(bus32.hi), 64'd0);
    chk("rst.lo",       64'(bus32.lo), 64'd0);
    @(negedge clk);
    rst = 1'b0; bus32.op_valid = 1'b0;
    @(posedge clk); #1;
    run32(3'd3, 32'd100, 32'd7, st, dn, dna, hi, lo);
    chk("rst.recover_stalls", 64'(st), 64'd33);
    chk("rst.recover_hi",     64'(hi), 64'd2);
    chk("rst.recover_lo",     64'(lo), 64'd14);

    // DATA_W=16, MUL_LAT=1 instance against the language-arithmetic reference.
    for (int i = 0; i < 16; i++) begin
      rop = 3'(i % 4);
      ra  = 16'($urandom);
      rb  = (i % 5 == 4) ? 16'h0 : 16'($urandom);
      if (i == 2) begin ra = 16'h8000; rb = 16'hFFFF; end
      if (i == 6) begin ra = 16'hFFF9; rb = 16'h0002; end
      exp16 = ref16(rop, ra, rb);
      run16(rop, ra, rb, st, dn, hilo);
      chk($sformatf("w16_%0d.stalls", i), 64'(st),   (rop[1] ? 64'd17 : 64'd2));
      chk($sformatf("w16_%0d.done", i),   64'(dn),   64'd1);
      chk($sformatf("w16_%0d.hilo op%0d a%0h b%0h", i, rop, ra, rb), 64'(hilo), 64'(exp16));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
